sisc_ctrl_mc: RTL and testbench
===============================

SISC_CTRL_MC -- requirements
Module: sisc_ctrl_mc

Interface
REQ-001 Parameter OPW, default 4: opcode and mm field width.
REQ-002 Parameter STW, default 4: status flag width.
REQ-003 Parameter TMO, default 15: maximum wait cycles for mem_rdy before timeout (1..255).
REQ-004 clk  in  1  clock; reset rst_f, asynchronous, active-low.
REQ-005 rst_f  in  1  async active-low reset.
REQ-006 opcode, mm  in  OPW each  instruction fields from IR; stat  in  STW  ALU status flags.
REQ-007 mem_rdy  in  1  memory completes the current access on this cycle.
REQ-008 mem_req, mem_we  out  1 each  memory access request and write enable.
REQ-009 rf_we, br_sel, pc_sel, ir_load, pc_write, pc_rst, rb_sel  out  1 each  datapath controls.
REQ-010 wb_sel  out  2  write-data source: 00 ALU, 01 memory, 10 swap register.
REQ-011 alu_op  out  2  00 ALU register form, 01 ALU immediate form, 10 pass/no arithmetic.
REQ-012 halted, err  out  1 each  HLT reached; memory timeout.
REQ-013 state  out  4  present state encoding, for debug.

Function
REQ-014 States (encoding): START0=0, START1=1, FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WB=6, WB2=7, HALT=8; unused encodings SHALL go to START0.
REQ-015 Opcodes: NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU=8, HLT=15, zero-extended to OPW; mm==8 means immediate.
REQ-016 START0->START1->FETCH unconditionally; pc_rst=1, pc_sel=1, br_sel=1 in both.
REQ-017 FETCH: mem_req=1, mem_we=0. Stay in FETCH until mem_rdy. On the mem_rdy cycle: ir_load=1, pc_write=1, pc_sel=0 (PC+1), next state DECODE.
REQ-018 DECODE: HLT->HALT; all other opcodes->EXECUTE. No control asserted.
REQ-019 EXECUTE branch evaluation: br_sel=1 for BRA/BNE, 0 for BRR/BNR. Taken when (stat&mm)!=0 for BRA/BRR and (stat&mm)==0 for BNE/BNR. Taken: pc_write=1, pc_sel=1 for exactly this one cycle.
REQ-020 EXECUTE next state: branches->FETCH; LOD/STR->MEM; ALU/SWP->WB; NOOP/others->FETCH.
REQ-021 MEM: mem_req=1, mem_we=1 for STR, 0 for LOD. Stay until mem_rdy. On mem_rdy: STR->FETCH, LOD->WB.
REQ-022 Wait counter: cleared on entering FETCH or MEM; increments each cycle mem_rdy=0. Reaching TMO without mem_rdy: HALT with err=1. A mem_rdy on the same cycle as count==TMO completes normally.
REQ-023 WB: rf_we=1 for ALU, LOD, SWP. wb_sel=01 for LOD, 10 for SWP, 00 otherwise. alu_op per REQ-024. Next state: WB2 for SWP (CTRL_SWP_EN), else FETCH.
REQ-024 alu_op=01 when opcode==ALU and mm==8; 00 when opcode==ALU otherwise; 10 for all other cases and states. Held through EXECUTE and WB.
REQ-025 HALT: absorbing until reset; halted=1; all strobes 0; err holds its value.
REQ-026 All controls not named for a state SHALL be 0, except alu_op=10; outputs decode from present state and inputs only.

Reset
REQ-027 rst_f=0: state->START1 immediately; wait counter=0, err=0.
REQ-028 During reset: pc_rst=1, all other strobes 0. A reset mid-MEM SHALL drop mem_req in the same delta, with no write completed.

Configuration
REQ-029 Macro CTRL_SWP_EN defined: SWP takes WB (rb_sel=0, rf_we, wb_sel=10), then WB2 (rb_sel=1, rf_we=1, wb_sel=00), then FETCH.
REQ-030 CTRL_SWP_EN undefined: SWP is treated as NOOP (EXECUTE->FETCH), and WB2 is unreachable.

Verification
REQ-031 Reset then mem_rdy tied 1, ADD register form (op=8, mm=0) -> states 1,2,3,4,6,2; alu_op=00 and rf_we=1 in WB.
REQ-032 BNE with stat=4'b0010, mm=4'b0001 -> pc_write=1, pc_sel=1, br_sel=1 in EXECUTE; with stat=4'b0001 -> pc_write=0.
REQ-033 LOD with mem_rdy delayed 3 cycles in MEM -> MEM held 4 cycles, then WB with wb_sel=01 and rf_we=1.
REQ-034 mem_rdy held 0 in FETCH, TMO=15 -> HALT after 15 wait cycles; err=1, halted=1.
REQ-035 SWP with CTRL_SWP_EN -> WB then WB2 (rb_sel=1), 2 rf_we pulses; without the macro -> 0 rf_we pulses.
REQ-036 HLT -> HALT entered after DECODE; rst_f pulse low -> START1, halted=0.

Source files
------------

// File: rtl/sisc_ctrl_mc.sv
// sisc_ctrl_mc: multi-cycle control unit for the SISC processor.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath strobes.
// Optional feature: define CTRL_SWP_EN to enable the two-cycle SWP writeback (WB then WB2).
// Without it, SWP behaves as NOOP and WB2 is never entered.
module sisc_ctrl_mc #(
  parameter int unsigned OPW = 4,
  parameter int unsigned STW = 4,
  parameter int unsigned TMO = 15
) (
  input  logic           clk,
  input  logic           rst_f,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] mm,
  input  logic [STW-1:0] stat,
  input  logic           mem_rdy,
  output logic           mem_req,
  output logic           mem_we,
  output logic           rf_we,
  output logic           br_sel,
  output logic           pc_sel,
  output logic           ir_load,
  output logic           pc_write,
  output logic           pc_rst,
  output logic           rb_sel,
  output logic [1:0]     wb_sel,
  output logic [1:0]     alu_op,
  output logic           halted,
  output logic           err,
  output logic [3:0]     state
);

  typedef enum logic [3:0] {
    StStart0  = 4'd0,
    StStart1  = 4'd1,
    StFetch   = 4'd2,
    StDecode  = 4'd3,
    StExecute = 4'd4,
    StMem     = 4'd5,
    StWb      = 4'd6,
    StWb2     = 4'd7,
    StHalt    = 4'd8
  } state_e;

  localparam logic [OPW-1:0] OpLod = OPW'(1);
  localparam logic [OPW-1:0] OpStr = OPW'(2);
  localparam logic [OPW-1:0] OpSwp = OPW'(3);
  localparam logic [OPW-1:0] OpBra = OPW'(4);
  localparam logic [OPW-1:0] OpBrr = OPW'(5);
  localparam logic [OPW-1:0] OpBne = OPW'(6);
  localparam logic [OPW-1:0] OpBnr = OPW'(7);
  localparam logic [OPW-1:0] OpAlu = OPW'(8);
  localparam logic [OPW-1:0] OpHlt = OPW'(15);
  localparam logic [OPW-1:0] MmImm = OPW'(8);

  localparam int unsigned MW = (OPW > STW) ? OPW : STW;
  localparam logic [7:0]  TmoCnt = 8'(TMO);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  logic is_lod, is_str, is_swp, is_alu, is_hlt;
  logic is_bra, is_brr, is_bne, is_bnr, is_br;
  logic flag_hit, br_taken, mem_tmo;
  logic [MW-1:0] hit_vec;
  logic [1:0] alu_mode;

  assign is_lod = (opcode == OpLod);
  assign is_str = (opcode == OpStr);
  assign is_swp = (opcode == OpSwp);
  assign is_alu = (opcode == OpAlu);
  assign is_hlt = (opcode == OpHlt);
  assign is_bra = (opcode == OpBra);
  assign is_brr = (opcode == OpBrr);
  assign is_bne = (opcode == OpBne);
  assign is_bnr = (opcode == OpBnr);
  assign is_br  = is_bra | is_brr | is_bne | is_bnr;

  assign hit_vec  = MW'(stat) & MW'(mm);
  assign flag_hit = |hit_vec;
  assign br_taken = ((is_bra | is_brr) & flag_hit) | ((is_bne | is_bnr) & ~flag_hit);
  // Timeout only fires when the memory is still not ready with the count at its limit.
  assign mem_tmo  = ~mem_rdy & (cnt_q == TmoCnt);
  assign alu_mode = is_alu ? ((mm == MmImm) ? 2'b01 : 2'b00) : 2'b10;

  // State, wait counter and sticky error register.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= StStart1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state, wait counting and timeout detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_d   = err_q;
    case (state_q)
      StStart0: state_d = StStart1;
      StStart1: state_d = StFetch;
      StFetch: begin
        if (mem_rdy) begin
          state_d = StDecode;
        end else if (mem_tmo) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDecode: state_d = is_hlt ? StHalt : StExecute;
      StExecute: begin
        if (is_br) begin
          state_d = StFetch;
        end else if (is_lod || is_str) begin
          state_d = StMem;
        end else if (is_alu) begin
          state_d = StWb;
`ifdef CTRL_SWP_EN
        end else if (is_swp) begin
          state_d = StWb;
`endif
        end else begin
          state_d = StFetch;
        end
      end
      StMem: begin
        if (mem_rdy) begin
          state_d = is_str ? StFetch : StWb;
        end else if (mem_tmo) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef CTRL_SWP_EN
      StWb:  state_d = is_swp ? StWb2 : StFetch;
`else
      StWb:  state_d = StFetch;
`endif
      StWb2: state_d = StFetch;
      StHalt: state_d = StHalt;
      default: state_d = StStart0;
    endcase
  end

  // Output decode from present state and inputs; reset forces only pc_rst.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    rf_we    = 1'b0;
    br_sel   = 1'b0;
    pc_sel   = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_rst   = 1'b0;
    rb_sel   = 1'b0;
    wb_sel   = 2'b00;
    alu_op   = 2'b10;
    if (!rst_f) begin
      pc_rst = 1'b1;
    end else begin
      case (state_q)
        StStart0, StStart1: begin
          pc_rst = 1'b1;
          pc_sel = 1'b1;
          br_sel = 1'b1;
        end
        StFetch: begin
          mem_req = 1'b1;
          if (mem_rdy) begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
          end
        end
        StExecute: begin
          alu_op = alu_mode;
          br_sel = is_bra | is_bne;
          if (is_br && br_taken) begin
            pc_write = 1'b1;
            pc_sel   = 1'b1;
          end
        end
        StMem: begin
          mem_req = 1'b1;
          mem_we  = is_str;
        end
        StWb: begin
          alu_op = alu_mode;
          rf_we  = is_alu | is_lod | is_swp;
          wb_sel = is_lod ? 2'b01 : (is_swp ? 2'b10 : 2'b00);
        end
        StWb2: begin
          rb_sel = 1'b1;
          rf_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted = (state_q == StHalt);
  assign err    = err_q;
  assign state  = state_q;

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Directed testbench for sisc_ctrl_mc (default parameters).
// Expectations for SWP follow CTRL_SWP_EN when it is defined for the build.
module tb_sisc_ctrl_mc;

  logic       clk;
  logic       rst_f;
  logic [3:0] opcode, mm, stat;
  logic       mem_rdy;
  logic       mem_req, mem_we, rf_we, br_sel, pc_sel, ir_load, pc_write, pc_rst, rb_sel;
  logic [1:0] wb_sel, alu_op;
  logic       halted, err;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  sisc_ctrl_mc dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .opcode   (opcode),
    .mm       (mm),
    .stat     (stat),
    .mem_rdy  (mem_rdy),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .rf_we    (rf_we),
    .br_sel   (br_sel),
    .pc_sel   (pc_sel),
    .ir_load  (ir_load),
    .pc_write (pc_write),
    .pc_rst   (pc_rst),
    .rb_sel   (rb_sel),
    .wb_sel   (wb_sel),
    .alu_op   (alu_op),
    .halted   (halted),
    .err      (err),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_f = 1'b1; mem_rdy = 1'b0; opcode = 4'd0; mm = 4'd0; stat = 4'd0;
    #1 rst_f = 1'b0;
    #1;
    check("rst_state", state, 1);
    check("rst_pc_rst", pc_rst, 1);
    check("rst_pc_sel", pc_sel, 0);
    check("rst_br_sel", br_sel, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_alu_op", alu_op, 2);
    check("rst_err", err, 0);
    check("rst_halted", halted, 0);

    // ADD register form with memory always ready
    #20 rst_f = 1'b1; mem_rdy = 1'b1; opcode = 4'd8; mm = 4'd0;
    #1;
    check("s1_state", state, 1);
    check("s1_pc_rst", pc_rst, 1);
    check("s1_pc_sel", pc_sel, 1);
    check("s1_br_sel", br_sel, 1);
    tick();
    check("fetch_state", state, 2);
    check("fetch_mem_req", mem_req, 1);
    check("fetch_mem_we", mem_we, 0);
    check("fetch_ir_load", ir_load, 1);
    check("fetch_pc_write", pc_write, 1);
    check("fetch_pc_sel", pc_sel, 0);
    check("fetch_pc_rst", pc_rst, 0);
    tick();
    check("dec_state", state, 3);
    check("dec_mem_req", mem_req, 0);
    check("dec_rf_we", rf_we, 0);
    check("dec_alu_op", alu_op, 2);
    tick();
    check("add_ex_state", state, 4);
    check("add_ex_alu_op", alu_op, 0);
    check("add_ex_rf_we", rf_we, 0);
    tick();
    check("add_wb_state", state, 6);
    check("add_wb_rf_we", rf_we, 1);
    check("add_wb_alu_op", alu_op, 0);
    check("add_wb_wb_sel", wb_sel, 0);
    tick();
    check("add_back_fetch", state, 2);

    // ALU immediate form
    mm = 4'd8;
    tick(); tick();
    check("imm_ex_alu_op", alu_op, 1);
    tick();
    check("imm_wb_state", state, 6);
    check("imm_wb_alu_op", alu_op, 1);
    tick();

    // BNE taken: stat & mm == 0
    opcode = 4'd6; mm = 4'd1; stat = 4'd2;
    tick(); tick();
    check("bne_t_state", state, 4);
    check("bne_t_pc_write", pc_write, 1);
    check("bne_t_pc_sel", pc_sel, 1);
    check("bne_t_br_sel", br_sel, 1);
    tick();
    check("bne_t_next", state, 2);
    // BNE not taken
    stat = 4'd1;
    tick(); tick();
    check("bne_n_pc_write", pc_write, 0);
    check("bne_n_pc_sel", pc_sel, 0);
    check("bne_n_br_sel", br_sel, 1);
    tick();
    // BRR taken: stat & mm != 0, relative target
    opcode = 4'd5;
    tick(); tick();
    check("brr_pc_write", pc_write, 1);
    check("brr_br_sel", br_sel, 0);
    tick();

    // NOOP
    opcode = 4'd0;
    tick(); tick();
    check("noop_state", state, 4);
    check("noop_alu_op", alu_op, 2);
    check("noop_pc_write", pc_write, 0);
    tick();
    check("noop_next", state, 2);

    // LOD with memory ready after three wait cycles
    opcode = 4'd1;
    tick(); tick(); tick();
    mem_rdy = 1'b0;
    #1;
    check("lod_mem_req", mem_req, 1);
    check("lod_mem_we", mem_we, 0);
    for (int k = 0; k < 4; k++) begin
      mem_rdy = (k == 3);
      #1;
      check("lod_mem_hold", state, 5);
      tick();
    end
    check("lod_wb_state", state, 6);
    check("lod_wb_sel", wb_sel, 1);
    check("lod_wb_rf_we", rf_we, 1);
    tick();
    check("lod_next", state, 2);

    // STR
    opcode = 4'd2;
    tick(); tick(); tick();
    check("str_state", state, 5);
    check("str_mem_we", mem_we, 1);
    check("str_mem_req", mem_req, 1);
    tick();
    check("str_next", state, 2);

    // SWP
    opcode = 4'd3;
    tick(); tick();
    check("swp_ex_rf_we", rf_we, 0);
    tick();
`ifdef CTRL_SWP_EN
    check("swp_wb_state", state, 6);
    check("swp_wb_rf_we", rf_we, 1);
    check("swp_wb_rb_sel", rb_sel, 0);
    check("swp_wb_sel", wb_sel, 2);
    tick();
    check("swp_wb2_state", state, 7);
    check("swp_wb2_rf_we", rf_we, 1);
    check("swp_wb2_rb_sel", rb_sel, 1);
    check("swp_wb2_sel", wb_sel, 0);
    tick();
`endif
    check("swp_next", state, 2);
    check("swp_fetch_rf_we", rf_we, 0);

    // Reset in the middle of a STR memory access
    opcode = 4'd2;
    tick(); tick(); tick();
    mem_rdy = 1'b0;
    #1;
    check("midmem_req_before", mem_req, 1);
    rst_f = 1'b0;
    #1;
    check("midmem_req", mem_req, 0);
    check("midmem_we", mem_we, 0);
    check("midmem_state", state, 1);
    check("midmem_pc_rst", pc_rst, 1);
    #1 rst_f = 1'b1;

    // Fetch timeout: memory never ready
    tick();
    check("tmo_ir_load", ir_load, 0);
    for (int i = 0; i < 16; i++) begin
      check("tmo_fetch_wait", state, 2);
      tick();
    end
    check("tmo_state", state, 8);
    check("tmo_err", err, 1);
    check("tmo_halted", halted, 1);
    check("tmo_mem_req", mem_req, 0);
    tick();
    check("tmo_absorb", state, 8);
    check("tmo_err_hold", err, 1);
    rst_f = 1'b0;
    #1;
    check("tmo_rst_err", err, 0);
    check("tmo_rst_halted", halted, 0);
    #2 rst_f = 1'b1;

    // Ready arriving exactly at the limit still completes
    tick();
    for (int i = 0; i < 15; i++) tick();
    mem_rdy = 1'b1;
    #1;
    check("lim_state", state, 2);
    check("lim_ir_load", ir_load, 1);
    tick();
    check("lim_decode", state, 3);
    check("lim_err", err, 0);

    // HLT from DECODE
    opcode = 4'd15;
    #1;
    tick();
    check("hlt_state", state, 8);
    check("hlt_halted", halted, 1);
    check("hlt_pc_write", pc_write, 0);
    check("hlt_err", err, 0);
    tick();
    check("hlt_absorb", state, 8);
    rst_f = 1'b0;
    #1;
    check("hlt_rst_state", state, 1);
    check("hlt_rst_halted", halted, 0);
    #1 rst_f = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
